rr_sel_arb4: RTL and testbench

- Round-robin arbiter that sits directly upstream of the max4to1 4:1 mux and drives its 2-bit select `s`.
- Four requesters each own one mux data lane (`d[i]`). The arbiter grants one lane at a time and holds `s` stable for the whole grant.
- A grant releases on consumer `done`, on requester withdrawal, or on a hold-limit timeout.
- The registered `s` connects straight to the mux `s` input; the mux output `o` is valid while `gnt_valid` is 1.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_sel_arb4.sv | 111 +++++++++++
 tb/tb_rr_sel_arb4.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the round-robin mux-select arbiter
package arb_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick: rotate, priority-encode, un-rotate
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [N_LANES-1:0] rot;
  logic [SEL_W-1:0]   lane;
  logic [SEL_W-1:0]   offs;

  // rot[i] is the request i places after ptr; lowest set bit wins, then map back to a lane
  always_comb begin
    rot  = '0;
    lane = '0;
    offs = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane   = SEL_W'(i) + ptr;
      rot[i] = req[lane];
    end
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (rot[i]) offs = SEL_W'(i);
    end
    found = |req;
    idx   = offs + ptr;
  end

endmodule

// File: rtl/rr_sel_arb4.sv
// rtl/rr_sel_arb4.sv - 4-lane round-robin arbiter driving a registered 4:1 mux select
module rr_sel_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   s,
  output logic [N_LANES-1:0] gnt,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [N_LANES-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               rel_done;
  logic               rel_wd;
  logic               rel_lim;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign rel_done = done;
  assign rel_wd   = ~req[s_q];
  assign rel_lim  = (hold_cnt_q == HOLD_LAST);

  // Next-state and output-register computation; timeout defaults low so it only pulses
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d          = GRANT;
          s_d              = pick_idx;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          gnt_valid_d      = 1'b1;
          hold_cnt_d       = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_wd || rel_lim) begin
          state_d     = GAP;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = s_q + 1'b1;
          // the limit only counts as a timeout when nothing else ended the grant
          timeout_d   = rel_lim && !rel_done && !rel_wd;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign s         = s_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel_arb4.sv
// tb/tb_rr_sel_arb4.sv - self-checking bench for rr_sel_arb4
module tb_rr_sel_arb4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  logic [3:0] req1;
  logic       done1;
  logic [1:0] s1;
  logic [3:0] gnt1;
  logic       gnt_valid1;
  logic       timeout1;

  logic [3:0] mux_d = 4'b1001;
  logic       mux_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] s;
    logic [3:0] gnt;
    logic       o;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign mux_o = mux_d[s];

  rr_sel_arb4 #(.MAX_HOLD(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .s         (s),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  rr_sel_arb4 #(.MAX_HOLD(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req1),
    .done      (done1),
    .s         (s1),
    .gnt       (gnt1),
    .gnt_valid (gnt_valid1),
    .timeout   (timeout1)
  );

  function automatic exp_t mk_exp(input int lane);
    exp_t e;
    e.s   = 2'(lane);
    e.gnt = 4'b0001 << lane;
    e.o   = mux_d[lane];
    return e;
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    exp_t e;
    bit   ok;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    req1 = 4'b0000;
    done1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({s, gnt, gnt_valid, timeout} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got s=%0d gnt=%b v=%b to=%b, want all 0", s, gnt, gnt_valid, timeout);
    end
    rst = 1'b0;
    req = 4'b0100;
    exp_q.push_back(mk_exp(2));
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_grant_wait: got no gnt_valid, want grant within bound");
    end else begin
      e = exp_q.pop_front();
      if ({s, gnt, mux_o} !== {e.s, e.gnt, e.o}) begin
        errors++;
        $display("FAIL basic_grant: got s=%0d gnt=%b o=%b, want s=%0d gnt=%b o=%b", s, gnt, mux_o, e.s, e.gnt, e.o);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s, gnt, gnt_valid, timeout} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset: got s=%0d gnt=%b v=%b to=%b, want all 0", s, gnt, gnt_valid, timeout);
    end
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    exp_t e;
    bit   ok;
    int   gap;
    int   lanes[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    foreach (lanes[k]) exp_q.push_back(mk_exp(lanes[k]));
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_first_wait: got no gnt_valid, want grant within bound");
      exp_q.delete();
    end else begin
      for (int k = 0; k < 5; k++) begin
        e = exp_q.pop_front();
        checks++;
        if ({s, gnt, gnt_valid, mux_o} !== {e.s, e.gnt, 1'b1, e.o}) begin
          errors++;
          $display("FAIL rr_grant%0d: got s=%0d gnt=%b v=%b o=%b, want s=%0d gnt=%b v=1 o=%b",
                   k, s, gnt, gnt_valid, mux_o, e.s, e.gnt, e.o);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        if (k < 4) begin
          gap = 0;
          while (!gnt_valid && gap < 10) begin
            gap++;
            @(negedge clk);
          end
          checks++;
          if (gap !== 2) begin
            errors++;
            $display("FAIL rr_gap%0d: got %0d idle cycles, want 2", k, gap);
          end
        end
      end
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    exp_t e;
    bit   ok;
    int   hcnt;
    req = 4'b0010;
    exp_q.push_back(mk_exp(1));
    exp_q.push_back(mk_exp(1));
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_wait: got no gnt_valid, want grant within bound");
    end
    e = exp_q.pop_front();
    if (ok && {s, gnt} !== {e.s, e.gnt}) begin
      errors++;
      $display("FAIL to_grant: got s=%0d gnt=%b, want s=%0d gnt=%b", s, gnt, e.s, e.gnt);
    end
    hcnt = 1;
    while (gnt_valid && hcnt < 300) begin
      @(negedge clk);
      if (gnt_valid) hcnt++;
    end
    checks++;
    if (hcnt !== 8) begin
      errors++;
      $display("FAIL to_hold_len: got %0d cycles, want 8", hcnt);
    end
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: got timeout=%b, want 1", timeout);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width: got timeout=%b, want 0", timeout);
    end
    wait_valid(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {s, gnt} !== {e.s, e.gnt}) begin
      errors++;
      $display("FAIL to_regrant: got v=%b s=%0d gnt=%b, want v=1 s=%0d gnt=%b", ok, s, gnt, e.s, e.gnt);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL coincide_still_held: got v=%b, want 1", gnt_valid);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 4'b0000;
    checks++;
    if ({gnt_valid, timeout} !== 2'b00) begin
      errors++;
      $display("FAIL coincide_done_wins: got v=%b timeout=%b, want v=0 timeout=0", gnt_valid, timeout);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdraw_wrap;
    exp_t e;
    bit   ok;
    req = 4'b1000;
    exp_q.push_back(mk_exp(3));
    exp_q.push_back(mk_exp(0));
    wait_valid(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {s, gnt} !== {e.s, e.gnt}) begin
      errors++;
      $display("FAIL wd_grant3: got v=%b s=%0d gnt=%b, want v=1 s=%0d gnt=%b", ok, s, gnt, e.s, e.gnt);
    end
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt_valid, timeout, gnt} !== 6'b0) begin
      errors++;
      $display("FAIL wd_release: got v=%b timeout=%b gnt=%b, want 0 0 0000", gnt_valid, timeout, gnt);
    end
    @(negedge clk);
    req = 4'b1001;
    wait_valid(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {s, gnt, mux_o} !== {e.s, e.gnt, e.o}) begin
      errors++;
      $display("FAIL wrap_grant0: got v=%b s=%0d gnt=%b o=%b, want v=1 s=%0d gnt=%b o=%b",
               ok, s, gnt, mux_o, e.s, e.gnt, e.o);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_hold;
    exp_t e;
    bit   ok;
    int   bad;
    req = 4'b0100;
    exp_q.push_back(mk_exp(2));
    wait_valid(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {s, gnt} !== {e.s, e.gnt}) begin
      errors++;
      $display("FAIL idle_grant2: got v=%b s=%0d gnt=%b, want v=1 s=%0d gnt=%b", ok, s, gnt, e.s, e.gnt);
    end
    req = 4'b0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({s, gnt, gnt_valid, timeout} !== {2'd2, 4'b0000, 1'b0, 1'b0}) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL idle_hold%0d: got s=%0d gnt=%b v=%b to=%b, want s=2 gnt=0000 v=0 to=0",
                   i, s, gnt, gnt_valid, timeout);
      end
    end
  endtask

  task automatic test_max_hold_one;
    bit ok;
    req1 = 4'b0001;
    for (int g = 0; g < 3; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (gnt_valid1) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || {s1, gnt1} !== {2'd0, 4'b0001}) begin
        errors++;
        $display("FAIL mh1_grant%0d: got v=%b s=%0d gnt=%b, want v=1 s=0 gnt=0001", g, ok, s1, gnt1);
      end
      if (g == 2) done1 = 1'b1;
      @(negedge clk);
      done1 = 1'b0;
      checks++;
      if ({gnt_valid1, timeout1} !== {1'b0, (g != 2)}) begin
        errors++;
        $display("FAIL mh1_release%0d: got v=%b timeout=%b, want v=0 timeout=%b", g, gnt_valid1, timeout1, (g != 2));
      end
    end
    req1 = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_withdraw_wrap();
    test_idle_hold();
    test_max_hold_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
